fifo_axis_credit_tx: RTL and testbench
======================================

# fifo_axis_credit_tx

Credit-based AXI-Stream transmitter that feeds a remote receive FIFO across a path where backpressure cannot be sampled in time, such as a long pipelined or SLR-crossing route. It accepts a local AXIS stream through a 2-entry skid buffer and issues beats on a registered valid-only output. Each issued beat consumes one credit. The remote FIFO returns credits as its entries drain, so the receiver never overflows and needs no ready signal.

## Interface
- FIFO_W, 512, data width in bits
- CREDITS, 64, receive-FIFO depth and initial credit count; 1..1023
- HAS_LAST, "false", "true" carries tlast through to tx_last_o; otherwise tx_last_o is tied 0
- RET_W, 2, width of the credit-return count port

Ports:
- clk  in  1  single clock for the whole block
- rst  in  1  asynchronous, active-high reset
- axis_data_i  in  FIFO_W  input beat data
- axis_valid_i  in  1  input valid
- axis_last_i  in  1  input last; ignored unless HAS_LAST=="true"
- axis_ready_o  out  1  input ready
- tx_data_o  out  FIFO_W  issued beat data (registered)
- tx_valid_o  out  1  issued beat strobe, one cycle per beat (registered)
- tx_last_o  out  1  issued last flag, qualified by tx_valid_o (registered)
- credit_ret_i  in  RET_W  credits returned this cycle; 0 means none
- credit_o  out  $clog2(CREDITS+1)  current credit count
- credit_err_o  out  1  sticky flag: returned credits pushed the count above CREDITS

## Operation
- Skid buffer
  - 2-entry FIFO holding {data, last}.
  - axis_ready_o = occupancy < 2, decoded from the occupancy register only; no combinational path from credits.
  - An input beat is accepted when axis_valid_i & axis_ready_o.
- Issue condition: skid buffer non-empty and credit_o > 0.
  - On the issuing edge, pop the head into the output register and set tx_valid_o=1 for one cycle.
  - Otherwise tx_valid_o=0 next cycle. tx_data_o is held (not cleared) when not valid.
- Credit update every cycle: next = credit_o - issue + credit_ret_i.
  - Compute in width $clog2(CREDITS+1)+RET_W+1 to avoid wrap.
  - If next > CREDITS: load CREDITS and set credit_err_o.
  - credit_err_o stays 1 until rst.
- Underflow cannot occur: issue requires credit_o ≥ 1.
- Ordering: beats leave in acceptance order; none are dropped or duplicated.
- The stream is beat-level only. The block does not interpret packet boundaries beyond forwarding last.
- States (implicit in registers):
  - EMPTY: occupancy 0.
  - ONE: occupancy 1.
  - FULL: occupancy 2, ready=0.
  - Transitions per edge: occupancy += accept - issue.
  - Simultaneous accept and issue in ONE stays ONE.
  - In FULL, an issue frees a slot, visible as ready=1 the following cycle.

## Timing
- Reset values:
  - axis_ready_o=1, tx_valid_o=0, tx_last_o=0, tx_data_o=0.
  - credit_o=CREDITS, credit_err_o=0, occupancy 0.
- Reset is asserted asynchronously. Deassertion is assumed synchronized upstream.
- Reset mid-stream discards buffered beats and restores full credit; the remote FIFO must be reset together.
- Latency: a beat accepted at edge N, with credit available, appears with tx_valid_o=1 in the cycle after edge N+1. Cut-through latency is therefore 2 cycles.
- Throughput: 1 beat/cycle sustained while credit_o ≥ 1.
- credit_ret_i sampled at edge N is usable for issue decisions from edge N+1.
- credit_o = 0 with a beat buffered: no issue. The first return restarts issue one cycle later.
- Issue and return in the same cycle both apply. With credit_o=1, issue, and ret=1, credit_o stays 1.

## Test plan
- Reset, then drive 10 back-to-back beats with data=i, no returns, CREDITS=64:
  - 10 tx_valid_o pulses with data 0..9.
  - First pulse 2 cycles after first accept.
  - credit_o ends at 54.
- CREDITS=4, stream 8 beats, no returns:
  - Exactly 4 issued; credit_o=0.
  - axis_ready_o falls once 2 beats are buffered.
  - Return credit_ret_i=1 for 4 cycles: remaining 4 beats issue, each 1 cycle after its credit; credit_o=0.
- Steady state with credit_o=1, issue and credit_ret_i=1 every cycle for 20 cycles:
  - Continuous tx_valid_o; credit_o constant at 1.
- HAS_LAST="true", 3-beat packet with last on beat 3:
  - tx_last_o=1 only with the 3rd tx_valid_o.
  - HAS_LAST="false": tx_last_o always 0.
- Overflow: at credit_o=CREDITS, drive credit_ret_i=2:
  - credit_o stays CREDITS; credit_err_o=1 and stays 1 until rst.
- Assert rst asynchronously with 2 beats buffered and credit_o=3:
  - Immediately tx_valid_o=0, credit_o=CREDITS, axis_ready_o=1.
  - No stale beat emitted after release.

Source files
------------

// File: rtl/fifo_axis_credit_tx.sv
// Credit-based AXI-Stream transmitter: a 2-entry skid buffer feeds a registered,
// valid-only output; each issued beat consumes one credit returned by the remote FIFO.
module fifo_axis_credit_tx #(
  parameter int unsigned FIFO_W   = 512,
  parameter int unsigned CREDITS  = 64,
  parameter string       HAS_LAST = "false",
  parameter int unsigned RET_W    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [FIFO_W-1:0]                axis_data_i,
  input  logic                             axis_valid_i,
  input  logic                             axis_last_i,
  output logic                             axis_ready_o,
  output logic [FIFO_W-1:0]                tx_data_o,
  output logic                             tx_valid_o,
  output logic                             tx_last_o,
  input  logic [RET_W-1:0]                 credit_ret_i,
  output logic [$clog2(CREDITS+1)-1:0]     credit_o,
  output logic                             credit_err_o
);

  localparam int unsigned CW       = $clog2(CREDITS + 1);
  localparam int unsigned EW       = CW + RET_W + 1;
  localparam bit          USE_LAST = (HAS_LAST == "true");

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_e;

  occ_e                    occ_q, occ_d;
  logic [1:0][FIFO_W-1:0]  buf_data_q;
  logic [1:0]              buf_last_q;
  logic                    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]           credit_q, credit_d;
  logic                    err_q, err_d;
  logic [EW-1:0]           credit_sum;
  logic [FIFO_W-1:0]       tx_data_q;
  logic                    tx_valid_q, tx_last_q;
  logic                    accept, issue;

  // Ready depends only on occupancy so no credit path reaches the upstream handshake.
  assign axis_ready_o = (occ_q != FULL);
  assign accept       = axis_valid_i & axis_ready_o;
  assign issue        = (occ_q != EMPTY) && (credit_q != '0);

  always_comb begin
    occ_d = occ_q;
    unique case (occ_q)
      EMPTY: if (accept) occ_d = ONE;
      ONE: begin
        if (accept && !issue)      occ_d = FULL;
        else if (!accept && issue) occ_d = EMPTY;
      end
      FULL:    if (issue) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

  // Widened sum so a return on a full count cannot wrap before the saturation test.
  always_comb begin
    credit_sum = EW'(credit_q) - EW'(issue) + EW'(credit_ret_i);
    credit_d   = credit_sum[CW-1:0];
    err_d      = err_q;
    if (credit_sum > EW'(CREDITS)) begin
      credit_d = CW'(CREDITS);
      err_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q      <= EMPTY;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      credit_q   <= CW'(CREDITS);
      err_q      <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      occ_q      <= occ_d;
      credit_q   <= credit_d;
      err_q      <= err_d;
      tx_valid_q <= issue;
      tx_last_q  <= issue & buf_last_q[rd_ptr_q];
      if (accept) wr_ptr_q <= ~wr_ptr_q;
      if (issue) begin
        rd_ptr_q  <= ~rd_ptr_q;
        tx_data_q <= buf_data_q[rd_ptr_q];
      end
    end
  end

  // Storage needs no reset: occupancy alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_data_q[wr_ptr_q] <= axis_data_i;
      buf_last_q[wr_ptr_q] <= axis_last_i & USE_LAST;
    end
  end

  assign tx_data_o    = tx_data_q;
  assign tx_valid_o   = tx_valid_q;
  assign tx_last_o    = tx_last_q;
  assign credit_o     = credit_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_fifo_axis_credit_tx.sv
// Bench for fifo_axis_credit_tx: two instances (4 credits with last, 64 credits without)
// checked every cycle against a queue-based reference model and scoreboard.
module tb_fifo_axis_credit_tx;

  localparam int DW = 32;
  localparam int CA = 4;
  localparam int CB = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DW-1:0] axis_data_i;
  logic          axis_valid_i, axis_last_i;
  logic [1:0]    credit_ret_i;

  logic          a_ready, a_valid, a_last, a_err;
  logic [DW-1:0] a_data;
  logic [2:0]    a_credit;
  logic          b_valid_in, b_ready, b_valid, b_last, b_err;
  logic [DW-1:0] b_data;
  logic [6:0]    b_credit;

  // Instance B only sees beats that instance A accepts, so both carry the same stream.
  assign b_valid_in = axis_valid_i & a_ready;

  fifo_axis_credit_tx #(.FIFO_W(DW), .CREDITS(CA), .HAS_LAST("true"), .RET_W(2)) u_dut_a (
    .clk(clk), .rst(rst), .axis_data_i(axis_data_i), .axis_valid_i(axis_valid_i),
    .axis_last_i(axis_last_i), .axis_ready_o(a_ready), .tx_data_o(a_data),
    .tx_valid_o(a_valid), .tx_last_o(a_last), .credit_ret_i(credit_ret_i),
    .credit_o(a_credit), .credit_err_o(a_err));

  fifo_axis_credit_tx #(.FIFO_W(DW), .CREDITS(CB), .HAS_LAST("false"), .RET_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .axis_data_i(axis_data_i), .axis_valid_i(b_valid_in),
    .axis_last_i(axis_last_i), .axis_ready_o(b_ready), .tx_data_o(b_data),
    .tx_valid_o(b_valid), .tx_last_o(b_last), .credit_ret_i(credit_ret_i),
    .credit_o(b_credit), .credit_err_o(b_err));

  int n_tests = 0;
  int n_fail  = 0;

  int            pend[2];
  int            cred[2];
  bit            err_m[2];
  bit            expv[2];
  logic [DW-1:0] hold[2];
  logic [DW:0]   qa[$];
  logic [DW:0]   qb[$];

  function automatic int cmax(input int k);
    return (k == 0) ? CA : CB;
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference model: beats waiting count, credit count, sticky error, expected strobe.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        pend[k]  = 0;
        cred[k]  = cmax(k);
        err_m[k] = 1'b0;
        expv[k]  = 1'b0;
        hold[k]  = '0;
      end
      qa.delete();
      qb.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit v, iss, acc;
        int nc;
        v   = (k == 0) ? axis_valid_i : b_valid_in;
        iss = (pend[k] > 0) && (cred[k] > 0);
        acc = v && (pend[k] < 2);
        if (acc) begin
          if (k == 0) qa.push_back({axis_last_i, axis_data_i});
          else        qb.push_back({1'b0, axis_data_i});
        end
        pend[k] = pend[k] + int'(acc) - int'(iss);
        nc = cred[k] - int'(iss) + int'(credit_ret_i);
        if (nc > cmax(k)) begin
          nc       = cmax(k);
          err_m[k] = 1'b1;
        end
        cred[k] = nc;
        expv[k] = iss;
      end
    end
  end

  task automatic mon(input int k, input logic rdy, input logic v, input logic [DW-1:0] d,
                     input logic l, input logic [63:0] crd, input logic e);
    logic [DW:0] item;
    bit empty;
    chk("ready", k, rdy, pend[k] < 2);
    chk("valid", k, v, expv[k]);
    chk("credit", k, crd, cred[k]);
    chk("credit_err", k, e, err_m[k]);
    if (v) begin
      empty = (k == 0) ? (qa.size() == 0) : (qb.size() == 0);
      if (empty) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_empty dut%0d: got beat %0h expected no beat at %0t", k, d, $time);
      end else begin
        if (k == 0) item = qa.pop_front();
        else        item = qb.pop_front();
        chk("data", k, d, item[DW-1:0]);
        chk("last", k, l, item[DW]);
        hold[k] = item[DW-1:0];
      end
    end else begin
      chk("data_hold", k, d, hold[k]);
      chk("last_idle", k, l, 1'b0);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon(0, a_ready, a_valid, a_data, a_last, a_credit, a_err);
      mon(1, b_ready, b_valid, b_data, b_last, b_credit, b_err);
    end
  end

  task automatic tick(input logic v, input logic [DW-1:0] d, input logic l,
                      input logic [1:0] r, output bit acc);
    axis_valid_i = v;
    axis_data_i  = d;
    axis_last_i  = l;
    credit_ret_i = r;
    @(negedge clk);
    acc = v && a_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic l, input logic [1:0] r);
    bit acc = 1'b0;
    for (int n = 0; n < 50 && !acc; n++) tick(1'b1, d, l, r, acc);
    n_tests++;
    if (!acc) begin
      n_fail++;
      $display("FAIL accept_timeout: ready low for 50 cycles, expected beat %0h accepted", d);
    end
  endtask

  task automatic do_reset();
    axis_valid_i = 1'b0;
    axis_last_i  = 1'b0;
    credit_ret_i = 2'd0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    int i;
    int r;
    logic [1:0] ret;
    axis_data_i = '0;
    do_reset();

    chk("rst_ready", 0, a_ready, 1'b1);
    chk("rst_valid", 0, a_valid, 1'b0);
    chk("rst_last", 0, a_last, 1'b0);
    chk("rst_data", 0, a_data, 0);
    chk("rst_credit", 0, a_credit, CA);
    chk("rst_err", 0, a_err, 1'b0);
    chk("rst_ready", 1, b_ready, 1'b1);
    chk("rst_credit", 1, b_credit, CB);

    // 8 beats against 4 credits, then four single-credit returns.
    i = 0;
    for (int c = 0; c < 32; c++) begin
      tick(i < 8, DW'(i), 1'b0, (c >= 20 && c < 24) ? 2'd1 : 2'd0, acc);
      if (acc) i++;
    end
    chk("p1_accepted", 0, i, 8);
    chk("p1_credit", 0, a_credit, 0);

    // Sustained traffic at one credit with a return every cycle.
    i = 100;
    for (int c = 0; c < 4; c++) begin
      tick(1'b1, DW'(i), 1'b0, 2'd0, acc);
      if (acc) i++;
    end
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, DW'(i), 1'b0, 2'd1, acc);
      if (acc) i++;
    end
    chk("steady_credit", 0, a_credit, 1);

    for (int c = 0; c < 4; c++) tick(1'b0, '0, 1'b0, 2'd1, acc);
    for (int b = 0; b < 3; b++) send(DW'(200 + b), b == 2, 2'd0);
    for (int c = 0; c < 4; c++) tick(1'b0, '0, 1'b0, 2'd0, acc);

    for (int c = 0; c < 400; c++) begin
      r   = $urandom_range(99);
      ret = (r < 60) ? 2'd0 : (r < 90) ? 2'd1 : (r < 98) ? 2'd2 : 2'd3;
      tick($urandom_range(9) < 7, DW'($urandom), 1'($urandom_range(1)), ret, acc);
    end
    do_reset();

    // Async reset with two beats buffered and credit count at 3.
    for (int c = 0; c < 10; c++) tick(1'b1, DW'(300 + c), 1'b0, 2'd0, acc);
    tick(1'b0, '0, 1'b0, 2'd3, acc);
    chk("pre_rst_credit", 0, a_credit, 3);
    chk("pre_rst_ready", 0, a_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 0, a_valid, 1'b0);
    chk("async_credit", 0, a_credit, CA);
    chk("async_ready", 0, a_ready, 1'b1);
    chk("async_credit", 1, b_credit, CB);
    credit_ret_i = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) tick(1'b0, '0, 1'b0, 2'd0, acc);

    // Overflow at full credit: count saturates, error sticks until reset.
    tick(1'b0, '0, 1'b0, 2'd2, acc);
    for (int c = 0; c < 3; c++) tick(1'b0, '0, 1'b0, 2'd0, acc);
    chk("ovf_err", 0, a_err, 1'b1);
    chk("ovf_credit", 0, a_credit, CA);
    chk("ovf_err", 1, b_err, 1'b1);
    chk("ovf_credit", 1, b_credit, CB);
    do_reset();
    chk("err_cleared", 0, a_err, 1'b0);
    chk("err_cleared", 1, b_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
